// File: rtl/hamming_share_ctrl.sv
// hamming_share_ctrl: shares one Hamming (7,4) check/correct datapath
// between two requesters with round-robin grant and a held result.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   req0_*             requester 0 (local word) valid/ready/word
//   req1_*             requester 1 (received word) valid/ready/word
//   dp_word_o          word driven to the shared datapath
//   dp_syndrome_i      datapath syndrome (0 = clean)
//   dp_corrected_i     datapath corrected word
//   res_*              held result with valid/ready handshake
//   err_cnt_o          saturating count of erroneous results
//   busy_o             controller not idle
//   inj_pos_i          error-injection bit position (HAMMING_ERR_INJECT_EN)
//
// Optional feature macro: HAMMING_ERR_INJECT_EN adds inj_pos_i; a nonzero
// value flips bit (inj_pos_i-1) of the word as it is latched.

module hamming_share_ctrl #(
   parameter int ERR_CNT_W = 8,
   parameter int HOLD_CYC  = 1000,
   parameter int HOLD_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid_i,
   input  logic [6:0]           req0_word_i,
   output logic                 req0_ready_o,
   input  logic                 req1_valid_i,
   input  logic [6:0]           req1_word_i,
   output logic                 req1_ready_o,
   output logic [6:0]           dp_word_o,
   input  logic [2:0]           dp_syndrome_i,
   input  logic [6:0]           dp_corrected_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic                 res_src_o,
   output logic [3:0]           res_data_o,
   output logic [2:0]           res_syndrome_o,
   output logic                 res_err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   output logic                 busy_o
`ifdef HAMMING_ERR_INJECT_EN
   ,
   input  logic [2:0]           inj_pos_i
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST =
      HOLD_W'((HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0);

   state_t               state;
   state_t               state_n;
   logic                 last;
   logic [6:0]           word_q;
   logic                 src_q;
   logic                 res_src_q;
   logic [3:0]           res_data_q;
   logic [2:0]           res_syn_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic [HOLD_W-1:0]    hold_cnt;
   logic                 busy_q;

   logic                 grant0;
   logic                 grant1;
   logic                 accept;
   logic                 hold_done;
   logic [6:0]           word_in;
   logic [6:0]           inj_mask;

   // Only the data positions of the corrected word reach the result.
   logic                 unused_corr;
   assign unused_corr = ^{dp_corrected_i[3], dp_corrected_i[1:0]};

   // With both requesters valid, the one not served last wins.
   assign grant0 = req0_valid_i & (~req1_valid_i | last);
   assign grant1 = req1_valid_i & (~req0_valid_i | ~last);

`ifdef HAMMING_ERR_INJECT_EN
   assign inj_mask = (inj_pos_i == 3'd0) ? 7'd0
                   : (7'd1 << (inj_pos_i - 3'd1));
`else
   assign inj_mask = 7'd0;
`endif

   assign word_in   = (grant1 ? req1_word_i : req0_word_i) ^ inj_mask;
   assign hold_done = (hold_cnt == HOLD_LAST);

   always_comb begin
      state_n      = state;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
      res_valid_o  = 1'b0;
      accept       = 1'b0;
      unique case (state)
         IDLE: begin
            req0_ready_o = grant0;
            req1_ready_o = grant1;
            accept       = grant0 | grant1;
            if (accept) begin
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            state_n = RESP;
         end
         RESP: begin
            res_valid_o = 1'b1;
            if (res_ready_i) begin
               state_n = (HOLD_CYC == 0) ? IDLE : HOLD;
            end
         end
         HOLD: begin
            if (hold_done) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy_q <= 1'b0;
      end else begin
         state  <= state_n;
         busy_q <= (state_n != IDLE);
      end
   end

   // Accept: latch word/source and move the round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= 7'd0;
         src_q  <= 1'b0;
         last   <= 1'b1;
      end else if (accept) begin
         word_q <= word_in;
         src_q  <= grant1;
         last   <= grant1;
      end
   end

   // Result capture at the end of ISSUE; kept until the next capture
   // so the display stays on the last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_src_q  <= 1'b0;
         res_data_q <= 4'd0;
         res_syn_q  <= 3'd0;
         err_cnt_q  <= '0;
      end else if (state == ISSUE) begin
         res_src_q  <= src_q;
         res_data_q <= {dp_corrected_i[6], dp_corrected_i[5],
                        dp_corrected_i[4], dp_corrected_i[2]};
         res_syn_q  <= dp_syndrome_i;
         if ((dp_syndrome_i != 3'd0) && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if ((state == HOLD) && !hold_done) begin
         hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
         hold_cnt <= '0;
      end
   end

   assign dp_word_o      = word_q;
   assign res_src_o      = res_src_q;
   assign res_data_o     = res_data_q;
   assign res_syndrome_o = res_syn_q;
   assign res_err_o      = |res_syn_q;
   assign err_cnt_o      = err_cnt_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_hamming_share_ctrl.sv
// tb_hamming_share_ctrl: directed bench for hamming_share_ctrl with a
// behavioural Hamming (7,4) datapath, HOLD_CYC=4 and a 2-bit counter.

module tb_hamming_share_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [6:0] req0_word, req1_word;
   logic       req0_ready, req1_ready;
   logic [6:0] dp_word;
   logic [2:0] dp_syn;
   logic [6:0] dp_corr;
   logic       res_valid, res_ready, res_src, res_err;
   logic [3:0] res_data;
   logic [2:0] res_syn;
   logic [1:0] err_cnt;
   logic       busy;
`ifdef HAMMING_ERR_INJECT_EN
   logic [2:0] inj_pos = 3'd0;
`endif

   int n_tot  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   hamming_share_ctrl #(
      .ERR_CNT_W(2),
      .HOLD_CYC (4),
      .HOLD_W   (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req0_valid_i  (req0_valid),
      .req0_word_i   (req0_word),
      .req0_ready_o  (req0_ready),
      .req1_valid_i  (req1_valid),
      .req1_word_i   (req1_word),
      .req1_ready_o  (req1_ready),
      .dp_word_o     (dp_word),
      .dp_syndrome_i (dp_syn),
      .dp_corrected_i(dp_corr),
      .res_valid_o   (res_valid),
      .res_ready_i   (res_ready),
      .res_src_o     (res_src),
      .res_data_o    (res_data),
      .res_syndrome_o(res_syn),
      .res_err_o     (res_err),
      .err_cnt_o     (err_cnt),
      .busy_o        (busy)
`ifdef HAMMING_ERR_INJECT_EN
      ,
      .inj_pos_i     (inj_pos)
`endif
   );

   // Behavioural shared datapath: syndrome bits over positions 1..7.
   always_comb begin
      dp_syn = {dp_word[3] ^ dp_word[4] ^ dp_word[5] ^ dp_word[6],
                dp_word[1] ^ dp_word[2] ^ dp_word[5] ^ dp_word[6],
                dp_word[0] ^ dp_word[2] ^ dp_word[4] ^ dp_word[6]};
      dp_corr = dp_word;
      if (dp_syn != 3'd0) begin
         dp_corr = dp_word ^ (7'd1 << (dp_syn - 3'd1));
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   logic [1:0] exp_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
   int n;

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0;
      req0_word = 0;  req1_word = 0;
      res_ready = 0;
      cyc(); cyc();
      chk("rst_outs", 32'({res_valid, dp_word, err_cnt, busy}), 32'd0);
      rst_n = 1'b1;
      cyc();

      // clean word from requester 0
      req0_valid = 1; req0_word = 7'b1010101;
      #1;
      chk("t1_ready", 32'({req0_ready, req1_ready}), 32'b10);
      cyc();
      req0_valid = 0;
      #1;
      chk("t1_issue", 32'({dp_word, busy, res_valid}), 32'({7'b1010101, 2'b10}));
      cyc();
      chk("t1_res", 32'({res_valid, res_src, res_data, res_err, res_syn}),
          32'({1'b1, 1'b0, 4'b1011, 1'b0, 3'd0}));
      chk("t1_cnt", 32'(err_cnt), 32'd0);
      res_ready = 1;
      cyc();
      res_ready = 0;
      chk("t1_drop", 32'({res_valid, res_data, busy}), 32'({1'b0, 4'b1011, 1'b1}));

      // single-bit error from requester 1
      req1_valid = 1; req1_word = 7'b1010001;
      #1;
      for (int k = 0; k < 20 && !req1_ready; k++) cyc();
      chk("t2_grant", 32'(req1_ready), 32'd1);
      cyc();
      req1_valid = 0;
      cyc();
      chk("t2_res", 32'({res_valid, res_src, res_syn, res_data, res_err}),
          32'({1'b1, 1'b1, 3'd3, 4'b1011, 1'b1}));
      chk("t2_cnt", 32'(err_cnt), 32'd1);
      res_ready = 1;
      cyc();
      for (int k = 0; k < 20 && busy; k++) cyc();
      chk("t2_idle", 32'(busy), 32'd0);

      // both valid: alternation and hold length
      req0_valid = 1; req0_word = 7'b1010101;
      req1_valid = 1; req1_word = 7'b0000000;
      #1;
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("t3_grant%0d", g), 32'({req0_ready, req1_ready}),
             32'({~exp_src[g][0], exp_src[g][0]}));
         cyc(); cyc();
         chk($sformatf("t3_src%0d", g), 32'({res_valid, res_src}),
             32'({1'b1, exp_src[g][0]}));
         n = 0;
         cyc();
         while (!(req0_ready | req1_ready) && n < 20) begin
            n++;
            cyc();
         end
         chk($sformatf("t3_hold%0d", g), 32'(n), 32'd4);
      end
      req0_valid = 0; req1_valid = 0; res_ready = 0;
      #1;
      chk("t3_cnt", 32'(err_cnt), 32'd1);

      // consumer stalls in RESP
      req0_valid = 1; req0_word = 7'b1010101;
      req1_valid = 1; req1_word = 7'b0000000;
      #1;
      chk("t4_grant", 32'({req0_ready, req1_ready}), 32'b10);
      cyc();
      req0_valid = 0;
      cyc();
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t4_stall%0d", i),
             32'({res_valid, res_src, res_data, res_syn, req0_ready, req1_ready}),
             32'({1'b1, 1'b0, 4'b1011, 3'd0, 2'b00}));
         cyc();
      end
      res_ready = 1;
      #1;
      cyc();
      chk("t4_hold", 32'({res_valid, busy, req1_ready, res_data}),
          32'({3'b010, 4'b1011}));
      for (int k = 0; k < 20 && !req1_ready; k++) cyc();
      chk("t4_grant1", 32'(req1_ready), 32'd1);
      cyc();
      req1_valid = 0;
      cyc();
      chk("t4_res1", 32'({res_valid, res_src, res_data}), 32'({2'b11, 4'b0000}));
      for (int k = 0; k < 20 && busy; k++) cyc();

      // counter saturation after a fresh reset
      rst_n = 0;
      #1;
      chk("t5_rst", 32'(err_cnt), 32'd0);
      cyc();
      rst_n = 1;
      cyc();
      req0_valid = 1; req0_word = 7'b1010001; res_ready = 1;
      #1;
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 20 && !req0_ready; k++) cyc();
         cyc(); cyc();
         chk($sformatf("t5_sat%0d", i), 32'({res_valid, res_err, err_cnt}),
             32'({2'b11, exp_sat[i]}));
      end
      req0_valid = 0;
      for (int k = 0; k < 20 && busy; k++) cyc();

      // reset while the datapath is being used
      req0_valid = 1; req0_word = 7'b1010001;
      #1;
      chk("t6_grant", 32'(req0_ready), 32'd1);
      cyc();
      req0_valid = 0;
      #1;
      chk("t6_issue", 32'({dp_word, busy}), 32'({7'b1010001, 1'b1}));
      rst_n = 0;
      req0_valid = 1; req1_valid = 1; req1_word = 7'b0000000;
      #1;
      chk("t6_rst", 32'({res_valid, dp_word, err_cnt, busy}), 32'd0);
      cyc();
      rst_n = 1;
      #1;
      chk("t6_first", 32'({req0_ready, req1_ready, res_valid}), 32'b100);
      cyc();
      req0_valid = 0; req1_valid = 0;
      cyc();
      chk("t6_res", 32'({res_valid, res_src, err_cnt}), 32'({2'b10, 2'd1}));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
